carfield_apb_periph_demux: RTL and testbench

- APB completer that receives peripheral-window requests from the AXI-to-APB bridge.
- Fans each request out to one of NumTargets APB peripherals: CAN, streamer, system timer, advanced timer, watchdog, HyperBus config.
- Decodes addresses against a runtime rule table supplied from the platform address map.
- Answers unmapped addresses with an error, aborts stalled targets after a bounded wait, and records the first error in sticky status outputs.

---
 rtl/carfield_apb_demux_pkg.sv | 19 +
 rtl/carfield_apb_addr_decoder.sv | 25 ++
 rtl/carfield_apb_periph_demux.sv | 137 +++++++++++++
 tb/tb_carfield_apb_periph_demux.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/carfield_apb_demux_pkg.sv
// carfield_apb_demux_pkg: shared types, state codes and default target map for the peripheral APB demux.
package carfield_apb_demux_pkg;
   typedef struct packed {
      logic [31:0] idx;
      logic [31:0] start_addr;
      logic [31:0] end_addr;
   } addr_rule_t;
   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ACCESS = 2'd1;
   localparam logic [1:0] ST_DECERR = 2'd2;
   localparam logic [1:0] ST_ABORT  = 2'd3;
   localparam logic [31:0] ERR_DATA_DEFAULT = 32'hBADCAB1E;
   localparam int unsigned IDX_CAN       = 0;
   localparam int unsigned IDX_STREAMER  = 1;
   localparam int unsigned IDX_TIMER     = 2;
   localparam int unsigned IDX_ADV_TIMER = 3;
   localparam int unsigned IDX_WATCHDOG  = 4;
   localparam int unsigned IDX_HYPERBUS  = 5;
endpackage

// File: rtl/carfield_apb_addr_decoder.sv
// carfield_apb_addr_decoder: matches an address against [start, end) rules; lowest matching index wins.
module carfield_apb_addr_decoder #(
   parameter int unsigned NumTargets = 6,
   parameter int unsigned AddrWidth  = 32,
   parameter int unsigned IdxWidth   = 3
)(
   input  logic [AddrWidth-1:0]            addr,
   input  logic [NumTargets*AddrWidth-1:0] rule_start,
   input  logic [NumTargets*AddrWidth-1:0] rule_end,
   input  logic [NumTargets-1:0]           rule_en,
   output logic [IdxWidth-1:0]             idx,
   output logic                            hit
);
   // Scan from the top down so the lowest matching index is written last.
   always_comb begin
      idx = '0;
      hit = 1'b0;
      for (int i = NumTargets - 1; i >= 0; i--)
         if (rule_en[i] && addr >= rule_start[i*AddrWidth +: AddrWidth] &&
             addr < rule_end[i*AddrWidth +: AddrWidth]) begin
            idx = IdxWidth'(i);
            hit = 1'b1;
         end
   end
endmodule

// File: rtl/carfield_apb_periph_demux.sv
// carfield_apb_periph_demux: APB 1-to-N demux with runtime address rules, decode-error and timeout responses,
// and sticky first-error status.
module carfield_apb_periph_demux
   import carfield_apb_demux_pkg::*;
#(
   parameter int unsigned          NumTargets    = 6,
   parameter int unsigned          AddrWidth     = 32,
   parameter int unsigned          DataWidth     = 32,
   parameter int unsigned          TimeoutCycles = 1024,
   parameter logic [DataWidth-1:0] ErrData       = DataWidth'(ERR_DATA_DEFAULT)
)(
   input  logic                            clk_i,
   input  logic                            rst_ni,
   input  logic [AddrWidth-1:0]            s_paddr_i,
   input  logic                            s_pwrite_i,
   input  logic [DataWidth-1:0]            s_pwdata_i,
   input  logic [DataWidth/8-1:0]          s_pstrb_i,
   input  logic [2:0]                      s_pprot_i,
   input  logic                            s_psel_i,
   input  logic                            s_penable_i,
   output logic [DataWidth-1:0]            s_prdata_o,
   output logic                            s_pready_o,
   output logic                            s_pslverr_o,
   output logic [AddrWidth-1:0]            m_paddr_o,
   output logic                            m_pwrite_o,
   output logic [DataWidth-1:0]            m_pwdata_o,
   output logic [DataWidth/8-1:0]          m_pstrb_o,
   output logic [2:0]                      m_pprot_o,
   output logic [NumTargets-1:0]           m_psel_o,
   output logic                            m_penable_o,
   input  logic [NumTargets*DataWidth-1:0] m_prdata_i,
   input  logic [NumTargets-1:0]           m_pready_i,
   input  logic [NumTargets-1:0]           m_pslverr_i,
   input  logic [NumTargets*AddrWidth-1:0] rule_start_i,
   input  logic [NumTargets*AddrWidth-1:0] rule_end_i,
   input  logic [NumTargets-1:0]           rule_en_i,
   output logic                            err_valid_o,
   output logic                            err_timeout_o,
   output logic [AddrWidth-1:0]            err_addr_o,
   input  logic                            err_clear_i
);
   localparam int unsigned IdxWidth = NumTargets > 1 ? $clog2(NumTargets) : 1;
   localparam int unsigned CntWidth = $clog2(TimeoutCycles + 1);
   logic [1:0]            state_q, state_d;
   logic [IdxWidth-1:0]   idx_q, dec_idx;
   logic                  dec_hit, setup, timeout;
   logic [CntWidth-1:0]   cnt_q;
   logic [NumTargets-1:0] sel;
   logic                  pen, rdy, slverr, err_set, err_kind;
   logic [DataWidth-1:0]  rdata;
   assign m_paddr_o  = s_paddr_i;
   assign m_pwrite_o = s_pwrite_i;
   assign m_pwdata_o = s_pwdata_i;
   assign m_pstrb_o  = s_pstrb_i;
   assign m_pprot_o  = s_pprot_i;
   assign setup      = s_psel_i & ~s_penable_i;
   assign timeout    = cnt_q == CntWidth'(TimeoutCycles - 1);
   carfield_apb_addr_decoder #(
      .NumTargets(NumTargets),
      .AddrWidth (AddrWidth),
      .IdxWidth  (IdxWidth)
   ) i_decoder (
      .addr      (s_paddr_i),
      .rule_start(rule_start_i),
      .rule_end  (rule_end_i),
      .rule_en   (rule_en_i),
      .idx       (dec_idx),
      .hit       (dec_hit)
   );
   always_comb begin
      state_d  = state_q;
      sel      = '0;
      pen      = 1'b0;
      rdy      = 1'b0;
      slverr   = 1'b0;
      rdata    = '0;
      err_set  = 1'b0;
      err_kind = 1'b0;
      case (state_q)
         ST_IDLE: if (setup) begin
            sel[dec_idx] = dec_hit;
            state_d      = dec_hit ? ST_ACCESS : ST_DECERR;
            err_set      = ~dec_hit;
         end
         ST_ACCESS: if (!s_psel_i) state_d = ST_IDLE;
         else begin
            sel[idx_q] = 1'b1;
            pen        = s_penable_i;
            if (s_penable_i && m_pready_i[idx_q]) begin
               rdy     = 1'b1;
               slverr  = m_pslverr_i[idx_q];
               rdata   = m_prdata_i[idx_q*DataWidth +: DataWidth];
               state_d = ST_IDLE;
            end else if (s_penable_i && timeout) begin
               state_d  = ST_ABORT;
               err_set  = 1'b1;
               err_kind = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            rdy     = s_psel_i & s_penable_i;
            slverr  = s_psel_i & s_penable_i;
            rdata   = (s_psel_i & s_penable_i) ? ErrData : '0;
         end
      endcase
   end
   // Reset gates the combinational paths so nothing leaks out while rst_ni is low.
   assign m_psel_o    = rst_ni ? sel : '0;
   assign m_penable_o = rst_ni & pen;
   assign s_pready_o  = rst_ni & rdy;
   assign s_pslverr_o = rst_ni & slverr;
   assign s_prdata_o  = rst_ni ? rdata : '0;
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q       <= ST_IDLE;
         idx_q         <= '0;
         cnt_q         <= '0;
         err_valid_o   <= 1'b0;
         err_timeout_o <= 1'b0;
         err_addr_o    <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= (state_q == ST_IDLE && setup) ? dec_idx : idx_q;
         cnt_q   <= (state_q == ST_ACCESS && s_penable_i) ? cnt_q + 1'b1 : '0;
         if (err_set && (!err_valid_o || err_clear_i)) begin
            err_valid_o   <= 1'b1;
            err_timeout_o <= err_kind;
            err_addr_o    <= s_paddr_i;
         end else if (err_clear_i) begin
            err_valid_o   <= 1'b0;
            err_timeout_o <= 1'b0;
            err_addr_o    <= '0;
         end
      end
   end
endmodule

// File: tb/tb_carfield_apb_periph_demux.sv
// tb_carfield_apb_periph_demux: directed bench for the peripheral APB demux with an 8-cycle timeout.
module tb_carfield_apb_periph_demux;
   localparam int N = 6;
   localparam int AW = 32;
   localparam int DW = 32;
   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic [AW-1:0]  paddr = '0;
   logic           pwrite = 1'b0;
   logic [DW-1:0]  pwdata = '0;
   logic [3:0]     pstrb = 4'hF;
   logic [2:0]     pprot = '0;
   logic           psel = 1'b0;
   logic           penable = 1'b0;
   logic [DW-1:0]  prdata;
   logic           pready, pslverr;
   logic [AW-1:0]  m_paddr;
   logic           m_pwrite;
   logic [DW-1:0]  m_pwdata;
   logic [3:0]     m_pstrb;
   logic [2:0]     m_pprot;
   logic [N-1:0]   m_psel;
   logic           m_penable;
   logic [N*DW-1:0] m_prdata = '0;
   logic [N-1:0]   m_pready = '0;
   logic [N-1:0]   m_pslverr = '0;
   logic [N*AW-1:0] rule_start, rule_end;
   logic [N-1:0]   rule_en = '1;
   logic           err_valid, err_timeout, err_clear = 1'b0;
   logic [AW-1:0]  err_addr;
   int checks = 0;
   int failures = 0;

   carfield_apb_periph_demux #(.TimeoutCycles(8)) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .s_paddr_i(paddr), .s_pwrite_i(pwrite), .s_pwdata_i(pwdata), .s_pstrb_i(pstrb), .s_pprot_i(pprot),
      .s_psel_i(psel), .s_penable_i(penable),
      .s_prdata_o(prdata), .s_pready_o(pready), .s_pslverr_o(pslverr),
      .m_paddr_o(m_paddr), .m_pwrite_o(m_pwrite), .m_pwdata_o(m_pwdata), .m_pstrb_o(m_pstrb), .m_pprot_o(m_pprot),
      .m_psel_o(m_psel), .m_penable_o(m_penable),
      .m_prdata_i(m_prdata), .m_pready_i(m_pready), .m_pslverr_i(m_pslverr),
      .rule_start_i(rule_start), .rule_end_i(rule_end), .rule_en_i(rule_en),
      .err_valid_o(err_valid), .err_timeout_o(err_timeout), .err_addr_o(err_addr), .err_clear_i(err_clear)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      rule_start = {32'h20029000, 32'h20007000, 32'h20005000, 32'h20004000, 32'h20029000, 32'h20001000};
      rule_end   = {32'h2002A000, 32'h20008000, 32'h20006000, 32'h20005000, 32'h20031000, 32'h20002000};
      // reset with a setup phase on the bus: nothing may leak out
      paddr = 32'h20001004; psel = 1'b1;
      #2;
      chk("rst_psel", m_psel, 0);
      chk("rst_pready", pready, 0);
      chk("rst_err_valid", err_valid, 0);
      psel = 1'b0;
      tick;
      rst_n = 1'b1;
      tick;
      // CAN read, two wait cycles
      paddr = 32'h20001004; pwrite = 1'b0; psel = 1'b1; penable = 1'b0;
      #1;
      chk("can_setup_psel", m_psel, 6'b000001);
      chk("can_setup_pen", m_penable, 0);
      chk("can_paddr_pass", m_paddr, 32'h20001004);
      tick; penable = 1'b1;
      #1;
      chk("can_acc1_pen", m_penable, 1);
      chk("can_acc1_rdy", pready, 0);
      tick;
      #1;
      chk("can_acc2_rdy", pready, 0);
      tick; m_pready = 6'b000001; m_prdata[0*DW +: DW] = 32'h1234;
      #1;
      chk("can_acc3_rdy", pready, 1);
      chk("can_acc3_data", prdata, 32'h1234);
      chk("can_acc3_err", pslverr, 0);
      // back-to-back unmapped write
      tick; m_pready = '0; paddr = 32'h20002000; pwrite = 1'b1; penable = 1'b0;
      #1;
      chk("miss_setup_psel", m_psel, 0);
      chk("miss_setup_rdy", pready, 0);
      tick; penable = 1'b1;
      #1;
      chk("miss_rdy", pready, 1);
      chk("miss_err", pslverr, 1);
      chk("miss_data", prdata, 32'hBADCAB1E);
      chk("miss_psel", m_psel, 0);
      tick; psel = 1'b0; penable = 1'b0;
      #1;
      chk("miss_idle_rdy", pready, 0);
      chk("miss_err_valid", err_valid, 1);
      chk("miss_err_timeout", err_timeout, 0);
      chk("miss_err_addr", err_addr, 32'h20002000);
      // watchdog never ready: abort after 8 access cycles
      tick; paddr = 32'h20007000; pwrite = 1'b0; psel = 1'b1;
      #1;
      chk("wd_setup_psel", m_psel, 6'b010000);
      tick; penable = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         #1;
         chk("wd_wait_psel", m_psel, 6'b010000);
         chk("wd_wait_rdy", pready, 0);
         tick;
      end
      m_pready = 6'b010000; m_prdata[4*DW +: DW] = 32'h5555; m_pslverr = '0;
      #1;
      chk("wd_abort_rdy", pready, 1);
      chk("wd_abort_err", pslverr, 1);
      chk("wd_abort_data", prdata, 32'hBADCAB1E);
      chk("wd_abort_psel", m_psel, 0);
      chk("wd_abort_pen", m_penable, 0);
      tick; psel = 1'b0; penable = 1'b0; m_pready = '0;
      #1;
      chk("wd_keep_timeout", err_timeout, 0);
      chk("wd_keep_addr", err_addr, 32'h20002000);
      err_clear = 1'b1;
      tick; err_clear = 1'b0;
      #1;
      chk("clear_valid", err_valid, 0);
      paddr = 32'h20007000; psel = 1'b1;
      tick; penable = 1'b1;
      repeat (8) tick;
      #1;
      chk("wd2_abort_rdy", pready, 1);
      tick; psel = 1'b0; penable = 1'b0;
      #1;
      chk("wd2_valid", err_valid, 1);
      chk("wd2_timeout", err_timeout, 1);
      chk("wd2_addr", err_addr, 32'h20007000);
      // overlapping rules: lower index wins
      tick; paddr = 32'h20029010; psel = 1'b1;
      #1;
      chk("ovl_psel", m_psel, 6'b000010);
      tick; penable = 1'b1; m_pready = 6'b100010;
      m_prdata[1*DW +: DW] = 32'hCAFE; m_prdata[5*DW +: DW] = 32'hBEEF;
      #1;
      chk("ovl_data", prdata, 32'hCAFE);
      tick; psel = 1'b0; penable = 1'b0; m_pready = '0;
      // upstream drops psel mid-access
      tick; paddr = 32'h20001000; psel = 1'b1;
      tick; penable = 1'b1;
      tick; psel = 1'b0; penable = 1'b0;
      #1;
      chk("drop_psel", m_psel, 0);
      chk("drop_rdy", pready, 0);
      // reset during timer access
      tick; paddr = 32'h20004000; psel = 1'b1;
      #1;
      chk("tmr_setup_psel", m_psel, 6'b000100);
      tick; penable = 1'b1;
      #1;
      chk("tmr_pen", m_penable, 1);
      m_pready = 6'b000100; m_prdata[2*DW +: DW] = 32'h7777;
      #1;
      rst_n = 1'b0;
      #1;
      chk("rst_mid_psel", m_psel, 0);
      chk("rst_mid_pen", m_penable, 0);
      chk("rst_mid_rdy", pready, 0);
      chk("rst_mid_err", pslverr, 0);
      chk("rst_mid_data", prdata, 0);
      chk("rst_mid_valid", err_valid, 0);
      psel = 1'b0; penable = 1'b0; m_pready = '0;
      tick;
      rst_n = 1'b1;
      tick; psel = 1'b1;
      #1;
      chk("tmr2_setup_psel", m_psel, 6'b000100);
      tick; penable = 1'b1; m_pready = 6'b000100; m_prdata[2*DW +: DW] = 32'hABCD;
      #1;
      chk("tmr2_rdy", pready, 1);
      chk("tmr2_data", prdata, 32'hABCD);
      tick; psel = 1'b0; penable = 1'b0; m_pready = '0;
      // clear coinciding with a new miss: the new error wins
      tick; paddr = 32'h20003000; psel = 1'b1;
      tick; penable = 1'b1;
      tick; psel = 1'b0; penable = 1'b0;
      #1;
      chk("pre_addr", err_addr, 32'h20003000);
      tick; paddr = 32'h30000000; psel = 1'b1; err_clear = 1'b1;
      tick; err_clear = 1'b0; penable = 1'b1;
      #1;
      chk("clrmiss_valid", err_valid, 1);
      chk("clrmiss_addr", err_addr, 32'h30000000);
      chk("clrmiss_timeout", err_timeout, 0);
      tick; psel = 1'b0; penable = 1'b0;
      tick;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
